// File: rtl/reg_file_pkg.sv
// Shared core package: datapath width, register addressing, opcode defines
// and a popcount helper used by the register scoreboard.
package reg_file_pkg;

  localparam int CORE_XLEN = 32;
  localparam int REG_AW    = 5;
  localparam logic [REG_AW-1:0] X0_IDX = 5'd0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-result scoreboard: tracks registers with outstanding writes, drives
// operand busy flags and the decode stall, and flags unexpected writebacks.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              stall_o,
  output logic [5:0]        pending_cnt_o,
  output logic              wb_err_o
);

  localparam int NSLOT = 2 ** REG_AW;

  logic [NSLOT-1:0] pending_q, pending_d;
  logic [NSLOT-1:0] eff_pending, wb_dec, set_dec, valid_mask;
  logic [5:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             issue_fire, wb_fire;

  // x0 and slots beyond NREG can never become pending
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_mask
    if (gi == int'(X0_IDX) || gi >= NREG) begin : g_tied
      assign valid_mask[gi] = 1'b0;
    end else begin : g_live
      assign valid_mask[gi] = 1'b1;
    end
  end

  always_comb begin
    wb_fire = wb_valid_i && (wb_rd_i != X0_IDX);
    wb_dec  = '0;
    if (wb_valid_i) wb_dec[wb_rd_i] = 1'b1;

    // a writeback landing this cycle already resolves its register
    eff_pending = pending_q & ~wb_dec;
    rs1_busy_o  = eff_pending[rs1_addr_i];
    rs2_busy_o  = eff_pending[rs2_addr_i];
    stall_o     = issue_valid_i && (rs1_busy_o || rs2_busy_o || eff_pending[issue_rd_i]);

    issue_fire = issue_valid_i && !stall_o && (issue_rd_i != X0_IDX);
    set_dec    = '0;
    if (issue_fire) set_dec[issue_rd_i] = 1'b1;

    // set is OR-ed after the clear so a same-cycle reissue stays pending
    pending_d = ((pending_q & ~wb_dec) | set_dec) & valid_mask;
    cnt_d     = popcount32(pending_d);
    err_d     = err_q | (wb_fire && !pending_q[wb_rd_i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      cnt_q     <= 6'd0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_cnt_o = cnt_q;
  assign wb_err_o      = err_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with writeback bypass; hazard tracking is
// delegated to reg_scoreboard.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN = CORE_XLEN,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] issue_rd_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              stall_o,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [5:0]        pending_cnt_o,
  output logic              wb_err_o
);

  localparam int NSLOT = 2 ** REG_AW;

  logic [XLEN-1:0]  reg_bank [NSLOT];
  logic [NSLOT-1:0] wr_dec;
  logic             wb_fire;
  logic             byp1, byp2;

  assign wb_fire = wb_valid_i && (wb_rd_i != X0_IDX);

  always_comb begin
    wr_dec = '0;
    if (wb_fire) wr_dec[wb_rd_i] = 1'b1;
  end

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_reg
    if (gi == int'(X0_IDX) || gi >= NREG) begin : g_zero
      assign reg_bank[gi] = '0;
    end else begin : g_flop
      logic [XLEN-1:0] data_q, data_d;

      always_comb begin
        data_d = data_q;
        if (wr_dec[gi]) data_d = wb_data_i;
      end

      always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
      end

      assign reg_bank[gi] = data_q;
    end
  end

  always_comb begin
    byp1       = wb_fire && (wb_rd_i == rs1_addr_i);
    byp2       = wb_fire && (wb_rd_i == rs2_addr_i);
    rs1_data_o = byp1 ? wb_data_i : reg_bank[rs1_addr_i];
    rs2_data_o = byp2 ? wb_data_i : reg_bank[rs2_addr_i];
  end

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .rs1_busy_o    (rs1_busy_o),
    .rs2_busy_o    (rs2_busy_o),
    .stall_o       (stall_o),
    .pending_cnt_o (pending_cnt_o),
    .wb_err_o      (wb_err_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, issue/writeback hazards, x0, WAW,
// writeback error flag and reset during activity.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o, stall_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic [5:0]  pending_cnt_o;
  logic        wb_err_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_data_o    (rs1_data_o),
    .rs2_data_o    (rs2_data_o),
    .rs1_busy_o    (rs1_busy_o),
    .rs2_busy_o    (rs2_busy_o),
    .stall_o       (stall_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .pending_cnt_o (pending_cnt_o),
    .wb_err_o      (wb_err_o)
  );

  // inputs change 1 time unit after the rising edge, checks sample 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0;
    wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'd0;
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
  endtask

  task automatic test_reset();
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
    issue_valid_i = 1'b1; issue_rd_i = 5'd4;
    #1;
    $display("reset_read: rs1=5 rs2=0 issue rd=4 (probe only)");
    vec_cnt++; if (rs1_data_o !== 32'd0) begin err_cnt++; $display("FAIL reset_rs1_data got %h exp 0", rs1_data_o); end
    vec_cnt++; if (rs2_data_o !== 32'd0) begin err_cnt++; $display("FAIL reset_rs2_data got %h exp 0", rs2_data_o); end
    vec_cnt++; if ({rs1_busy_o, rs2_busy_o} !== 2'b00) begin err_cnt++; $display("FAIL reset_busy got %b exp 00", {rs1_busy_o, rs2_busy_o}); end
    vec_cnt++; if (stall_o !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    vec_cnt++; if (pending_cnt_o !== 6'd0) begin err_cnt++; $display("FAIL reset_cnt got %0d exp 0", pending_cnt_o); end
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL reset_err got %b exp 0", wb_err_o); end
    idle();
  endtask

  task automatic test_issue_wb();
    issue_valid_i = 1'b1; issue_rd_i = 5'd3;
    #1;
    $display("c0: issue rd=3");
    vec_cnt++; if (stall_o !== 1'b0) begin err_cnt++; $display("FAIL iw_c0_stall got %b exp 0", stall_o); end
    tick();
    issue_valid_i = 1'b1; issue_rd_i = 5'd10; rs1_addr_i = 5'd3;
    #1;
    $display("c1: issue rd=10 rs1=3 (x3 pending)");
    vec_cnt++; if (rs1_busy_o !== 1'b1) begin err_cnt++; $display("FAIL iw_c1_busy got %b exp 1", rs1_busy_o); end
    vec_cnt++; if (stall_o !== 1'b1) begin err_cnt++; $display("FAIL iw_c1_stall got %b exp 1", stall_o); end
    vec_cnt++; if (pending_cnt_o !== 6'd1) begin err_cnt++; $display("FAIL iw_c1_cnt got %0d exp 1", pending_cnt_o); end
    tick();
    issue_valid_i = 1'b1; issue_rd_i = 5'd3;
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
    #1;
    $display("c2: wb rd=3 data=deadbeef rs1=3");
    vec_cnt++; if (rs1_data_o !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL iw_c2_bypass got %h exp deadbeef", rs1_data_o); end
    vec_cnt++; if (rs1_busy_o !== 1'b0) begin err_cnt++; $display("FAIL iw_c2_busy got %b exp 0", rs1_busy_o); end
    vec_cnt++; if (stall_o !== 1'b0) begin err_cnt++; $display("FAIL iw_c2_stall got %b exp 0", stall_o); end
    issue_valid_i = 1'b0;
    tick();
    wb_valid_i = 1'b0;
    #1;
    $display("c3: read rs1=3 from storage");
    vec_cnt++; if (pending_cnt_o !== 6'd0) begin err_cnt++; $display("FAIL iw_c3_cnt got %0d exp 0", pending_cnt_o); end
    vec_cnt++; if (rs1_data_o !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL iw_c3_data got %h exp deadbeef", rs1_data_o); end
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL iw_c3_err got %b exp 0", wb_err_o); end
    idle();
  endtask

  task automatic test_x0();
    wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234;
    issue_valid_i = 1'b1; issue_rd_i = 5'd0; rs1_addr_i = 5'd0;
    #1;
    $display("x0: wb rd=0 data=1234 issue rd=0");
    vec_cnt++; if (rs1_data_o !== 32'd0) begin err_cnt++; $display("FAIL x0_bypass got %h exp 0", rs1_data_o); end
    vec_cnt++; if (stall_o !== 1'b0) begin err_cnt++; $display("FAIL x0_stall got %b exp 0", stall_o); end
    tick();
    idle();
    #1;
    $display("x0: read back");
    vec_cnt++; if (rs1_data_o !== 32'd0) begin err_cnt++; $display("FAIL x0_read got %h exp 0", rs1_data_o); end
    vec_cnt++; if (pending_cnt_o !== 6'd0) begin err_cnt++; $display("FAIL x0_cnt got %0d exp 0", pending_cnt_o); end
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL x0_err got %b exp 0", wb_err_o); end
  endtask

  task automatic test_waw();
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    $display("waw: issue rd=7");
    tick();
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    #1;
    $display("waw: reissue rd=7 without wb");
    vec_cnt++; if (stall_o !== 1'b1) begin err_cnt++; $display("FAIL waw_stall got %b exp 1", stall_o); end
    vec_cnt++; if (pending_cnt_o !== 6'd1) begin err_cnt++; $display("FAIL waw_cnt_pre got %0d exp 1", pending_cnt_o); end
    wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h77;
    #1;
    $display("waw: reissue rd=7 with wb rd=7 data=77");
    vec_cnt++; if (stall_o !== 1'b0) begin err_cnt++; $display("FAIL waw_wb_stall got %b exp 0", stall_o); end
    tick();
    idle();
    rs1_addr_i = 5'd7;
    #1;
    $display("waw: after same-cycle issue/wb");
    vec_cnt++; if (rs1_busy_o !== 1'b1) begin err_cnt++; $display("FAIL waw_busy got %b exp 1", rs1_busy_o); end
    vec_cnt++; if (pending_cnt_o !== 6'd1) begin err_cnt++; $display("FAIL waw_cnt got %0d exp 1", pending_cnt_o); end
    vec_cnt++; if (rs1_data_o !== 32'h77) begin err_cnt++; $display("FAIL waw_data got %h exp 77", rs1_data_o); end
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL waw_err got %b exp 0", wb_err_o); end
    wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h78;
    $display("waw: retire rd=7");
    tick();
    idle();
    #1;
    vec_cnt++; if (pending_cnt_o !== 6'd0) begin err_cnt++; $display("FAIL waw_retire_cnt got %0d exp 0", pending_cnt_o); end
  endtask

  task automatic test_error();
    wb_valid_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h55;
    #1;
    $display("err: wb rd=9 data=55 (x9 not pending)");
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL err_same_cycle got %b exp 0", wb_err_o); end
    tick();
    idle();
    rs1_addr_i = 5'd9;
    #1;
    vec_cnt++; if (wb_err_o !== 1'b1) begin err_cnt++; $display("FAIL err_set got %b exp 1", wb_err_o); end
    vec_cnt++; if (rs1_data_o !== 32'h55) begin err_cnt++; $display("FAIL err_data got %h exp 55", rs1_data_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      $display("err: hold cycle %0d", i);
      vec_cnt++; if (wb_err_o !== 1'b1) begin err_cnt++; $display("FAIL err_hold%0d got %b exp 1", i, wb_err_o); end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] rds [4];
    rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd4; rds[3] = 5'd5;
    for (int i = 0; i < 4; i++) begin
      idle();
      issue_valid_i = 1'b1; issue_rd_i = rds[i];
      $display("rmid: issue rd=%0d", rds[i]);
      tick();
    end
    idle();
    #1;
    vec_cnt++; if (pending_cnt_o !== 6'd4) begin err_cnt++; $display("FAIL rmid_cnt_pre got %0d exp 4", pending_cnt_o); end
    reset = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'hAA;
    $display("rmid: reset with wb rd=2 data=aa");
    tick();
    reset = 1'b0;
    idle();
    rs1_addr_i = 5'd2; rs2_addr_i = 5'd3;
    #1;
    vec_cnt++; if (pending_cnt_o !== 6'd0) begin err_cnt++; $display("FAIL rmid_cnt got %0d exp 0", pending_cnt_o); end
    vec_cnt++; if (rs1_data_o !== 32'd0) begin err_cnt++; $display("FAIL rmid_x2 got %h exp 0", rs1_data_o); end
    vec_cnt++; if (rs2_data_o !== 32'd0) begin err_cnt++; $display("FAIL rmid_x3 got %h exp 0", rs2_data_o); end
    vec_cnt++; if (rs1_busy_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got %b exp 0", rs1_busy_o); end
    vec_cnt++; if (wb_err_o !== 1'b0) begin err_cnt++; $display("FAIL rmid_err got %b exp 0", wb_err_o); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_issue_wb();
    test_x0();
    test_waw();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; index 0 is the hardwired zero register x0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port issue_valid_i  input  1  decode is issuing an instruction that writes rd.
REQ-006 SHALL have port issue_rd_i  input  5  destination register of the issuing instruction.
REQ-007 SHALL have ports rs1_addr_i, rs2_addr_i  input  5 each  source register addresses from decode.
REQ-008 SHALL have ports rs1_data_o, rs2_data_o  output  XLEN each  source operand data.
REQ-009 SHALL have ports rs1_busy_o, rs2_busy_o  output  1 each  source has an outstanding, not-yet-written result.
REQ-010 SHALL have port stall_o  output  1  decode must hold the current instruction.
REQ-011 SHALL have ports wb_valid_i  input  1; wb_rd_i  input  5; wb_data_i  input  XLEN  writeback-stage write port.
REQ-012 SHALL have port pending_cnt_o  output  6  registered count of pending registers.
REQ-013 SHALL have port wb_err_o  output  1  sticky flag: a writeback targeted a non-pending register.

Function
REQ-014 SHALL read register contents combinationally; x0 SHALL always read 0.
REQ-015 SHALL bypass: when wb_valid_i=1, wb_rd_i!=0, and wb_rd_i equals rsN_addr_i, rsN_data_o SHALL equal wb_data_i in the same cycle.
REQ-016 SHALL write wb_data_i into wb_rd_i at posedge when wb_valid_i=1 and wb_rd_i!=0; writes to x0 SHALL be discarded.
REQ-017 SHALL keep one pending bit per register; pending[0] SHALL be constant 0.
REQ-018 SHALL define eff_pending[r] = pending[r] AND NOT (wb_valid_i AND wb_rd_i==r), i.e. a same-cycle writeback counts as resolved.
REQ-019 SHALL drive rsN_busy_o = eff_pending[rsN_addr_i].
REQ-020 SHALL drive stall_o = issue_valid_i AND (rs1_busy_o OR rs2_busy_o OR eff_pending[issue_rd_i]); the last term covers WAW.
REQ-021 SHALL set pending[issue_rd_i] at posedge when issue_valid_i=1, stall_o=0, and issue_rd_i!=0.
REQ-022 SHALL clear pending[wb_rd_i] at posedge on a valid writeback with wb_rd_i!=0.
REQ-023 SHALL let set win over clear when issue and writeback target the same register in the same cycle, so pending stays 1.
REQ-024 SHALL set wb_err_o at posedge on a valid writeback with wb_rd_i!=0 and pending[wb_rd_i]=0; the write SHALL still occur; wb_err_o SHALL remain set until reset.
REQ-025 SHALL update pending_cnt_o one cycle after the pending vector changes, as the popcount of the new pending vector (0..31).

Reset
REQ-026 SHALL, at posedge with reset=1, zero all registers, clear all pending bits, clear wb_err_o, and zero pending_cnt_o.
REQ-027 SHALL give reset priority over simultaneous issue or writeback; a writeback in the reset cycle is lost.
REQ-028 SHALL produce these combinational outputs after reset: rs1_data_o=0, rs2_data_o=0, busy flags=0, stall_o=0.

Structure
REQ-029 SHALL take XLEN, the register address width (5), and the x0 index constant from the shared core package, which already holds the opcode defines.
REQ-030 SHALL place the pending vector, eff_pending, busy/stall logic, and popcount in one sub-module, reg_scoreboard; reg_file SHALL hold the storage array and bypass muxes.

Verification
REQ-031 SHALL cover reset then reads: rs1=5, rs2=0 -> data 0/0, busy 0/0, stall 0, pending_cnt_o=0.
REQ-032 SHALL cover issue then writeback: issue rd=3 in cycle 0 -> cycle 1 rs1=3 gives busy=1, stall=1 with issue_valid; wb rd=3 data=0xDEADBEEF in cycle 2 -> same cycle rs1_data_o=0xDEADBEEF, busy=0, stall=0; cycle 3 pending_cnt_o=0.
REQ-033 SHALL cover x0: wb rd=0 data=0x1234 and issue rd=0 -> rs1=0 reads 0, pending_cnt_o unchanged, wb_err_o=0.
REQ-034 SHALL cover WAW and same-cycle issue/writeback: with x7 pending, issue rd=7 without wb -> stall=1; with wb rd=7 in the same cycle -> stall=0, pending[7] stays 1, pending_cnt_o stays 1.
REQ-035 SHALL cover error: wb rd=9 data=0x55 with x9 not pending -> next cycle wb_err_o=1 and x9 reads 0x55; flag holds across 10 cycles and clears only on reset.
REQ-036 SHALL cover reset mid-operation: 4 registers pending, reset asserted with wb rd=2 -> next cycle pending_cnt_o=0, x2 reads 0, wb_err_o=0.
